// File: rtl/residue_node.sv
// residue_node: output-layer membrane-potential store answering sum-stage residue requests
// and streaming the per-timestep spike bitmap to the output node as four byte packets.
module residue_node #(
    parameter int         WIDTH       = 35,
    parameter int         NUM_NEURONS = 25,
    parameter logic [3:0] RES_ADDR    = 4'b1100,
    parameter logic [3:0] SUM_ADDR    = 4'b0000,
    parameter logic [3:0] OUT_ADDR    = 4'b0011,
    parameter logic [7:0] INIT_POT    = 8'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       ts_count,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, REPLY, FLUSH} state_t;

    state_t                 r_state;
    logic [7:0]             r_pot [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] r_bitmap;
    logic [1:0]             r_k;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_data;
    logic [7:0]             r_ts;
    logic                   r_err;

    logic [3:0]  w_dst;
    logic [1:0]  w_op;
    logic        w_spike;
    logic [6:0]  w_zero;
    logic [4:0]  w_idx;
    logic [7:0]  w_data;
    logic        w_bad;
    logic        w_accept;
    logic [31:0] w_bm32;

    assign w_dst    = in_data[30:27];
    assign w_op     = in_data[22:21];
    assign w_spike  = in_data[20];
    assign w_zero   = in_data[19:13];
    assign w_idx    = in_data[12:8];
    assign w_data   = in_data[7:0];
    assign w_bad    = (w_dst != RES_ADDR) || (w_op == 2'b11) || (32'(w_idx) >= NUM_NEURONS) || (w_zero != 7'd0);
    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && in_ready;
    // Bitmap bits above NUM_NEURONS read as zero in the flush bytes.
    assign w_bm32   = 32'(r_bitmap);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign ts_count  = r_ts;
    assign err       = r_err;

    function automatic logic [34:0] f_flush(input logic [1:0] k, input logic [31:0] bm);
        return {RES_ADDR, OUT_ADDR, RES_ADDR, 2'b10, 1'b0, 7'b0, 3'b0, k, bm[{k, 3'b000} +: 8]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bitmap    <= '0;
            r_k         <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ts        <= 8'd0;
            r_err       <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) r_pot[i] <= INIT_POT;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    if (w_bad) begin
                        r_err <= 1'b1;
                    end else if (w_op == 2'b00) begin
                        r_state     <= REPLY;
                        r_out_valid <= 1'b1;
                        r_out_data  <= {RES_ADDR, SUM_ADDR, RES_ADDR, 2'b00, 1'b0, 7'b0, w_idx, r_pot[w_idx]};
                    end else if (w_op == 2'b01) begin
                        r_pot[w_idx]    <= w_data;
                        r_bitmap[w_idx] <= r_bitmap[w_idx] | w_spike;
                    end else begin
                        r_state     <= FLUSH;
                        r_k         <= 2'd0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= f_flush(2'd0, w_bm32);
                    end
                end
                REPLY: if (out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
                FLUSH: if (out_ready) begin
                    if (r_k == 2'd3) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_bitmap    <= '0;
                        r_ts        <= r_ts + 8'd1;
                    end else begin
                        r_k        <= r_k + 2'd1;
                        r_out_data <= f_flush(r_k + 2'd1, w_bm32);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_residue_node.sv
// tb_residue_node: table-driven packet vectors plus hand sequences for stall, reset-mid-flush
// and timestep-counter wrap.
module tb_residue_node;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, err;
    logic [34:0] in_data, out_data;
    logic [7:0]  ts_count;
    int          total = 0, bad = 0;

    residue_node dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ts_count(ts_count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [34:0] pkt;
        int          kind;
        logic [34:0] exp_out;
        logic [31:0] exp_bm;
        logic [7:0]  exp_ts;
        logic        exp_err;
    } vec_t;

    vec_t v[20];

    function automatic logic [34:0] mk(input logic [3:0] dst, input logic [1:0] op, input logic s,
                                       input logic [6:0] z, input logic [4:0] idx, input logic [7:0] d);
        return {4'h0, dst, 4'h0, op, s, z, idx, d};
    endfunction

    function automatic logic [34:0] rp(input logic [4:0] idx, input logic [7:0] d);
        return {4'hC, 4'h0, 4'hC, 2'b00, 1'b0, 7'b0, idx, d};
    endfunction

    function automatic logic [34:0] fp(input int k, input logic [31:0] bm);
        logic [4:0] kk;
        logic [7:0] b;
        kk = 5'(k);
        b  = bm[k*8 +: 8];
        return {4'hC, 4'h3, 4'hC, 2'b10, 1'b0, 7'b0, kk, b};
    endfunction

    function automatic vec_t mv(input logic [34:0] p, input int kind, input logic [34:0] eo,
                                input logic [31:0] bm, input logic [7:0] ts, input logic e);
        vec_t r;
        r.pkt = p; r.kind = kind; r.exp_out = eo; r.exp_bm = bm; r.exp_ts = ts; r.exp_err = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [34:0] p);
        int n = 0;
        in_data  = p;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 35'(n), 35'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reply(input string nm, input logic [34:0] exp);
        chk({nm, "_valid"}, 35'(out_valid), 35'd1);
        chk({nm, "_data"}, out_data, exp);
        chk({nm, "_inrdy"}, 35'(in_ready), 35'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_done"}, 35'(out_valid), 35'd0);
    endtask

    task automatic do_flush(input string nm, input logic [31:0] bm);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk({nm, "_fvalid"}, 35'(out_valid), 35'd1);
            chk({nm, "_fdata"}, out_data, fp(k, bm));
            chk({nm, "_finrdy"}, 35'(in_ready), 35'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk({nm, "_fend_valid"}, 35'(out_valid), 35'd0);
        chk({nm, "_fend_inrdy"}, 35'(in_ready), 35'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        v[0]  = mv(mk(4'hC, 2'b00, 0, 7'd0, 5'd7, 8'h00), 1, rp(5'd7, 8'h00), 0, 8'd0, 0);
        v[1]  = mv(mk(4'hC, 2'b01, 1, 7'd0, 5'd3, 8'h2A), 0, 0, 0, 8'd0, 0);
        v[2]  = mv(mk(4'hC, 2'b00, 0, 7'd0, 5'd3, 8'h00), 1, rp(5'd3, 8'h2A), 0, 8'd0, 0);
        v[3]  = mv(mk(4'hC, 2'b10, 0, 7'd0, 5'd0, 8'h00), 2, 0, 32'h0000_0008, 8'd1, 0);
        v[4]  = mv(mk(4'hC, 2'b01, 1, 7'd0, 5'd0, 8'h11), 0, 0, 0, 8'd1, 0);
        v[5]  = mv(mk(4'hC, 2'b01, 1, 7'd0, 5'd9, 8'h99), 0, 0, 0, 8'd1, 0);
        v[6]  = mv(mk(4'hC, 2'b01, 1, 7'd0, 5'd24, 8'h55), 0, 0, 0, 8'd1, 0);
        v[7]  = mv(mk(4'hC, 2'b10, 0, 7'd0, 5'd0, 8'h00), 2, 0, 32'h0100_0201, 8'd2, 0);
        v[8]  = mv(mk(4'hC, 2'b10, 0, 7'd0, 5'd0, 8'h00), 2, 0, 32'h0000_0000, 8'd3, 0);
        v[9]  = mv(mk(4'hC, 2'b00, 0, 7'd0, 5'd3, 8'h00), 1, rp(5'd3, 8'h2A), 0, 8'd3, 0);
        v[10] = mv(mk(4'hC, 2'b00, 0, 7'd0, 5'd24, 8'h00), 1, rp(5'd24, 8'h55), 0, 8'd3, 0);
        v[11] = mv(mk(4'hC, 2'b01, 0, 7'd0, 5'd9, 8'h77), 0, 0, 0, 8'd3, 0);
        v[12] = mv(mk(4'hC, 2'b00, 0, 7'd0, 5'd9, 8'h00), 1, rp(5'd9, 8'h77), 0, 8'd3, 0);
        v[13] = mv(mk(4'hC, 2'b00, 0, 7'd0, 5'd25, 8'h00), 0, 0, 0, 8'd3, 1);
        v[14] = mv(mk(4'h3, 2'b00, 0, 7'd0, 5'd1, 8'h00), 0, 0, 0, 8'd3, 1);
        v[15] = mv(mk(4'hC, 2'b11, 0, 7'd0, 5'd1, 8'h00), 0, 0, 0, 8'd3, 1);
        v[16] = mv(mk(4'hC, 2'b00, 0, 7'h10, 5'd1, 8'h00), 0, 0, 0, 8'd3, 1);
        v[17] = mv(mk(4'h0, 2'b01, 1, 7'd0, 5'd2, 8'hFF), 0, 0, 0, 8'd3, 1);
        v[18] = mv(mk(4'hC, 2'b00, 0, 7'd0, 5'd2, 8'h00), 1, rp(5'd2, 8'h00), 0, 8'd3, 1);
        v[19] = mv(mk(4'hC, 2'b00, 0, 7'd0, 5'd0, 8'h00), 1, rp(5'd0, 8'h11), 0, 8'd3, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 35'(out_valid), 35'd0);
        chk("rst_data", out_data, 35'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_valid", 35'(out_valid), 35'd0);
        chk("rel_ts", 35'(ts_count), 35'd0);
        chk("rel_err", 35'(err), 35'd0);
        chk("rel_inrdy", 35'(in_ready), 35'd1);

        foreach (v[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            send(v[i].pkt);
            if (v[i].kind == 1) do_reply(nm, v[i].exp_out);
            else if (v[i].kind == 2) do_flush(nm, v[i].exp_bm);
            else begin
                chk({nm, "_noreply"}, 35'(out_valid), 35'd0);
                chk({nm, "_inrdy"}, 35'(in_ready), 35'd1);
            end
            chk({nm, "_ts"}, 35'(ts_count), 35'(v[i].exp_ts));
            chk({nm, "_err"}, 35'(err), 35'(v[i].exp_err));
        end

        send(mk(4'hC, 2'b00, 0, 7'd0, 5'd3, 8'h00));
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 35'(out_valid), 35'd1);
            chk("stall_data", out_data, rp(5'd3, 8'h2A));
            chk("stall_inrdy", 35'(in_ready), 35'd0);
            @(posedge clk); #1;
        end
        do_reply("stall_end", rp(5'd3, 8'h2A));

        send(mk(4'hC, 2'b01, 1, 7'd0, 5'd5, 8'h66));
        send(mk(4'hC, 2'b10, 0, 7'd0, 5'd0, 8'h00));
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        chk("midflush_k2", out_data, fp(2, 32'h0000_0020));
        #2 rst_n = 1'b0;
        #1;
        chk("midflush_rst_valid", 35'(out_valid), 35'd0);
        chk("midflush_rst_ts", 35'(ts_count), 35'd0);
        chk("midflush_rst_err", 35'(err), 35'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("after_rst_idle", 35'(out_valid), 35'd0);
        end
        out_ready = 1'b0;
        send(mk(4'hC, 2'b00, 0, 7'd0, 5'd3, 8'h00));
        do_reply("after_rst_pot", rp(5'd3, 8'h00));
        send(mk(4'hC, 2'b10, 0, 7'd0, 5'd0, 8'h00));
        do_flush("after_rst_bm", 32'h0);
        chk("after_rst_ts", 35'(ts_count), 35'd1);

        out_ready = 1'b1;
        for (int t = 0; t < 255; t++) begin
            if (t == 254) chk("wrap_pre", 35'(ts_count), 35'd255);
            send(mk(4'hC, 2'b10, 0, 7'd0, 5'd0, 8'h00));
            repeat (4) @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        chk("wrap_ts", 35'(ts_count), 35'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/residue_node.md
# residue_node

Membrane-potential store for the output layer of the SNN accelerator, sitting at NoC address 4'b1100 directly upstream of the sum & threshold stage (address 4'b0000). It answers residue requests from the sum stage with the stored potential of one neuron. It absorbs the updated potential and spike flag the sum stage returns. At each timestep end it streams the accumulated spike bitmap to the output node as byte packets.

## Interface
- WIDTH, 35, packet width
- NUM_NEURONS, 25, output neurons held (1..32)
- RES_ADDR, 4'b1100, own NoC address
- SUM_ADDR, 4'b0000, sum & threshold node address
- OUT_ADDR, 4'b0011, spike-bitmap destination address
- INIT_POT, 8'd0, potential loaded at reset

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input packet valid
- in_ready  out  1  input packet accepted when in_valid && in_ready
- in_data  in  35  input packet
- out_valid  out  1  output packet valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  35  output packet
- ts_count  out  8  completed timesteps, wraps
- err  out  1  sticky malformed-packet flag

## Operation
- Packet fields: [34:31] src, [30:27] dst, [26:23] src copy, [22:21] opcode, [20] spike, [19:13] zero, [12:8] index, [7:0] data.
- Input opcodes:
  - 00 RES_REQ: read pot[index].
  - 01 RES_UPDATE: pot[index] <= data; bitmap[index] <= bitmap[index] | spike.
  - 10 TS_END.
  - 11 is illegal.
- Storage: pot[NUM_NEURONS] of 8 bits; bitmap of NUM_NEURONS bits.
- FSM states IDLE, REPLY, FLUSH.
  - IDLE: in_ready=1. Accepted RES_REQ → REPLY. RES_UPDATE → stay IDLE. TS_END → FLUSH with k=0.
  - REPLY: out_valid=1. out_data = {RES_ADDR, SUM_ADDR, RES_ADDR, 2'b00, 1'b0, 7'b0, index, pot[index]}. On out_ready → IDLE.
  - FLUSH: out_valid=1, emitting packet k for k=0..3. out_data = {RES_ADDR, OUT_ADDR, RES_ADDR, 2'b10, 1'b0, 7'b0, k[4:0], bitmap[8k+7:8k]}. Bits at index ≥ NUM_NEURONS read 0. On out_ready with k<3, k increments. On out_ready with k=3: clear bitmap, ts_count+1 (255→0), → IDLE.
- Malformed packet: dst≠RES_ADDR, opcode 11, index ≥ NUM_NEURONS, or bits [19:13]≠0.
  - The packet is consumed in IDLE with no state or storage change and no reply.
  - err is set and held until reset.
- Potentials persist across timesteps; only the bitmap clears at flush.
- A RES_REQ following a RES_UPDATE to the same index returns the updated value.

## Timing
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, out_data=0, ts_count=0, err=0, bitmap=0, all pot=INIT_POT.
- Reset asserted mid-REPLY or mid-FLUSH drops out_valid immediately. The partial flush is abandoned and not resumed.
- RES_REQ accepted at edge N → out_valid high after edge N, REPLY latency 1 cycle.
- RES_UPDATE accepted at edge N → storage written at edge N. A request accepted at N+1 sees the new value.
- in_ready is combinationally 1 only in IDLE. Packets are never dropped while in_ready=0.
- out_data and out_valid hold stable while out_valid && !out_ready.
- With out_ready held high, FLUSH takes exactly 4 cycles; in_ready returns the cycle after packet 3 is accepted.
- Back-to-back: IDLE accepts a new packet in the cycle after REPLY or FLUSH completes. Minimum REQ-to-REQ spacing is 2 cycles.

## Test plan
- Reset release → out_valid=0, ts_count=0, err=0. RES_REQ idx 7 → reply data 8'd0 (INIT_POT), [12:8]=7, dst 4'b0000, out_valid 1 cycle after acceptance.
- RES_UPDATE idx 3 data 8'h2A spike 1, then RES_REQ idx 3 → reply data 8'h2A. Hold out_ready=0 for 5 cycles → out_data stable, in_ready=0 throughout.
- Updates with spike on idx 0, 9, 24, then TS_END → four packets to OUT_ADDR in order:
  - k=0 data 8'h01
  - k=1 data 8'h02
  - k=2 data 8'h00
  - k=3 data 8'h01
  - ts_count=1; a second TS_END gives all-zero bytes while potentials are retained.
- RES_REQ idx 25, wrong dst, and opcode 11 → each consumed, no reply, err=1 and sticky; a following valid request is answered normally.
- rst_n pulsed low during FLUSH after k=1 → out_valid drops immediately, bitmap, ts_count and pot return to reset values, no remaining flush packets.
- 256 TS_END packets → ts_count wraps to 0.
